pipe_stage_hs: RTL and testbench

PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

---
 rtl/pipe_stage_hs.sv | 71 +++++++
 tb/tb_pipe_stage_hs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready register pipeline with DEPTH stages, bubble collapse and synchronous flush.
// Each stage advances when it is empty or when the stage ahead of it drains.
module pipe_stage_hs #(
    parameter int W        = 32,
    parameter int DEPTH    = 2,
    parameter int CLR_DATA = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]        v, v_nxt, up_v;
    logic [DEPTH-1:0][W-1:0] d, up_d;
    logic [DEPTH:0]          rdy;

    function automatic logic [OW-1:0] popcnt(input logic [DEPTH-1:0] x);
        logic [OW-1:0] c;
        c = '0;
        for (int k = 0; k < DEPTH; k++) c = c + OW'(x[k]);
        return c;
    endfunction

    assign rdy[DEPTH] = out_ready;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stg
            // A stage is free to load if empty or if whatever it holds moves on this edge.
            assign rdy[i] = ~v[i] | rdy[i+1];
            if (i == 0) begin : g_head
                assign up_v[i] = in_valid;
                assign up_d[i] = in_data;
            end else begin : g_body
                assign up_v[i] = v[i-1];
                assign up_d[i] = d[i-1];
            end
            assign v_nxt[i] = flush ? 1'b0 : (rdy[i] ? up_v[i] : v[i]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            v         <= '0;
            d         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= popcnt(v_nxt);
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) begin
                    if (CLR_DATA != 0) d[k] <= '0;
                end else if (rdy[k] && up_v[k]) begin
                    d[k] <= up_d[k];
                end
            end
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: two configurations driven together, checked against an item/slot model.
// The model tracks each payload's stage position and moves items forward by the handshake rules.
module tb_pipe_stage_hs;
    localparam int D0 = 2, D1 = 4;
    localparam int CLR0 = 1, CLR1 = 0;

    logic        clk, reset, flush, in_valid, or0, or1;
    logic [31:0] in_data;
    logic        ir0, ir1, ov0, ov1;
    logic [31:0] od0;
    logic [15:0] od1;
    logic [1:0]  occ0;
    logic [2:0]  occ1;

    int checks = 0, errors = 0;
    bit armed = 0;

    int          cnt  [2];
    int          pos  [2][9];
    logic [31:0] dat  [2][9];
    logic [31:0] last [2];

    pipe_stage_hs #(.W(32), .DEPTH(D0), .CLR_DATA(CLR0)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0));

    pipe_stage_hs #(.W(16), .DEPTH(D1), .CLR_DATA(CLR1)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data[15:0]), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Evaluate one model against current inputs; commit advances it across the coming edge.
    task automatic model(input int m, input bit commit, output bit ird);
        int dp, n, p;
        bit clr, ordy;
        logic [31:0] msk, nl;
        int np [9];
        logic [31:0] nd [9];
        dp   = (m == 0) ? D0 : D1;
        clr  = (m == 0) ? (CLR0 != 0) : (CLR1 != 0);
        ordy = (m == 0) ? or0 : or1;
        msk  = (m == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        n = 0;
        nl = last[m];
        for (int k = 0; k < cnt[m]; k++) begin
            p = pos[m][k];
            if (!(p == dp - 1 && ordy)) begin
                if (p == dp - 1 || (n > 0 && np[n-1] == p + 1)) np[n] = p;
                else begin
                    np[n] = p + 1;
                    if (p + 1 == dp - 1) nl = dat[m][k];
                end
                nd[n] = dat[m][k];
                n++;
            end
        end
        ird = !flush && !(n > 0 && np[n-1] == 0);
        if (commit) begin
            if (reset) begin
                cnt[m] = 0; last[m] = 0;
            end else if (flush) begin
                cnt[m] = 0;
                if (clr) last[m] = 0;
            end else begin
                if (ird && in_valid) begin
                    np[n] = 0; nd[n] = in_data & msk;
                    if (dp == 1) nl = nd[n];
                    n++;
                end
                for (int k = 0; k < n; k++) begin
                    pos[m][k] = np[k]; dat[m][k] = nd[k];
                end
                cnt[m] = n; last[m] = nl;
            end
        end
    endtask

    function automatic logic exp_ov(input int m);
        int dp;
        dp = (m == 0) ? D0 : D1;
        return cnt[m] > 0 && pos[m][0] == dp - 1;
    endfunction

    task automatic cyc(input bit r, input bit f, input bit iv, input logic [31:0] id,
                       input bit o0, input bit o1);
        bit e;
        @(negedge clk);
        reset = r; flush = f; in_valid = iv; in_data = id; or0 = o0; or1 = o1;
        #1;
        if (armed) begin
            model(0, 0, e);
            chk("u0_in_ready", 32'(ir0), 32'(e));
            chk("u0_out_valid", 32'(ov0), 32'(exp_ov(0)));
            chk("u0_out_data", od0, last[0]);
            chk("u0_occupancy", 32'(occ0), 32'(cnt[0]));
            model(1, 0, e);
            chk("u1_in_ready", 32'(ir1), 32'(e));
            chk("u1_out_valid", 32'(ov1), 32'(exp_ov(1)));
            chk("u1_out_data", 32'(od1), last[1]);
            chk("u1_occupancy", 32'(occ1), 32'(cnt[1]));
        end
        model(0, 1, e);
        model(1, 1, e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_data = 0; or0 = 0; or1 = 0;
        for (int m = 0; m < 2; m++) begin cnt[m] = 0; last[m] = 0; end

        cyc(1, 0, 0, 0, 1, 1);
        armed = 1;
        cyc(1, 1, 1, 32'hDEAD, 1, 1);
        after_edge();
        reset = 0; flush = 0; in_valid = 0; #1;
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_out_data", od0, 0);
        chk("rst_in_ready", 32'(ir0), 1);
        chk("rst_occupancy", 32'(occ1), 0);

        // streaming 1,2,3 with no back-pressure
        cyc(0, 0, 1, 32'h1, 1, 1);
        cyc(0, 0, 1, 32'h2, 1, 1);
        after_edge();
        chk("stream_first_valid", 32'(ov0), 1);
        chk("stream_first_data", od0, 32'h1);
        chk("stream_occ", 32'(occ0), 2);
        cyc(0, 0, 1, 32'h3, 1, 1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 1);

        // u1 under full back-pressure: fills to DEPTH, then refuses the fifth
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 32'hA0 + k, 1, 0);
        after_edge();
        chk("bp_occ", 32'(occ1), 4);
        chk("bp_in_ready", 32'(ir1), 0);
        chk("bp_out_data", 32'(od1), 32'hA0);
        cyc(0, 0, 1, 32'hA4, 1, 1);
        for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, 1, 1);

        // flush with a payload at the output being consumed
        cyc(0, 0, 1, 32'h11, 0, 0);
        cyc(0, 0, 1, 32'h22, 0, 0);
        cyc(0, 1, 1, 32'h33, 1, 1);
        after_edge();
        chk("flush_u0_valid", 32'(ov0), 0);
        chk("flush_u0_data_cleared", od0, 0);
        chk("flush_u0_occ", 32'(occ0), 0);
        chk("flush_u1_data_held", 32'(od1), 32'hA4);
        for (int k = 1; k <= 3; k++) cyc(0, 0, 1, k, 1, 1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, 1);

        // reset with flush while u1 is full
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, 32'h40 + k, 1, 0);
        cyc(1, 1, 1, 32'h55, 1, 0);
        after_edge();
        reset = 0; flush = 0; in_valid = 0; #1;
        chk("rst_busy_valid", 32'(ov1), 0);
        chk("rst_busy_data", 32'(od1), 0);
        chk("rst_busy_occ", 32'(occ1), 0);
        chk("rst_busy_in_ready", 32'(ir1), 1);

        // randomized traffic
        for (int k = 0; k < 4000; k++)
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 7), $urandom,
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
